// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider (signed or unsigned) producing quotient,
// remainder and a divide-by-zero flag; one quotient bit is resolved per cycle.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    count;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             b_zero;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] trial;
    logic             q_bit;
    logic             last_step;

    // Operand conditioning and one restoring-division step
    always_comb begin
        mag_a     = (signed_op && A[WIDTH-1]) ? WIDTH'(-A) : A;
        mag_b     = (signed_op && B[WIDTH-1]) ? WIDTH'(-B) : B;
        b_zero    = (B == '0);
        rem_shift = {rem, dvd[WIDTH-1]};
        q_bit     = (rem_shift >= {1'b0, dsr});
        trial     = WIDTH'(rem_shift - {1'b0, dsr});
        last_step = (count == CW'(1));
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = b_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (last_step) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_IDLE:  busy = 1'b0;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b1;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dvd       <= '0;
            dsr       <= '0;
            rem       <= '0;
            count     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        neg_q <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r <= signed_op & A[WIDTH-1];
                        if (b_zero) begin
                            quotient  <= '1;
                            remainder <= A;
                            div_zero  <= 1'b1;
                        end else begin
                            dvd   <= mag_a;
                            dsr   <= mag_b;
                            rem   <= '0;
                            count <= CW'(WIDTH);
                        end
                    end
                end
                S_CALC: begin
                    rem   <= q_bit ? trial : rem_shift[WIDTH-1:0];
                    dvd   <= {dvd[WIDTH-2:0], q_bit};
                    count <= count - CW'(1);
                end
                S_FIX: begin
                    quotient  <= neg_q ? WIDTH'(-dvd) : dvd;
                    remainder <= neg_r ? WIDTH'(-rem) : rem;
                    div_zero  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider: hand-computed quotient/remainder vectors,
// latency, start-while-busy immunity and asynchronous reset mid-operation.
module tb_seq_divider;

    logic        CLK;
    logic        RST;
    logic        start;
    logic        signed_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int n_vec;
    int n_bad;

    seq_divider #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .signed_op (signed_op),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive start for one edge (edge 1 samples it), then wait for done and check.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int glitch_edge, input int exp_edge,
                          input logic [31:0] eq, input logic [31:0] er, input logic ez);
        int  edge_n;
        int  pulses;
        bit  seen;
        @(posedge CLK); #1;
        A = a; B = b; signed_op = s; start = 1'b1;
        @(posedge CLK); #1;
        start  = 1'b0;
        edge_n = 1;
        chk({tag, ".busy_e1"}, 32'(busy), 32'd1);
        seen = 1'b0;
        while (!seen && edge_n < 80) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (edge_n == glitch_edge) begin
                    start = 1'b1; A = ~a; B = b + 32'd1; signed_op = ~s;
                end else begin
                    start = 1'b0;
                end
                @(posedge CLK); #1;
                edge_n++;
            end
        end
        start = 1'b0;
        chk({tag, ".done_seen"}, 32'(seen), 32'd1);
        chk({tag, ".latency"}, 32'(edge_n), 32'(exp_edge));
        chk({tag, ".q"}, quotient, eq);
        chk({tag, ".r"}, remainder, er);
        chk({tag, ".dz"}, 32'(div_zero), 32'(ez));
        chk({tag, ".busy_done"}, 32'(busy), 32'd1);
        @(posedge CLK); #1;
        chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            pulses += int'(done);
            @(posedge CLK); #1;
        end
        chk({tag, ".extra_done"}, 32'(pulses), 32'd0);
        chk({tag, ".q_hold"}, quotient, eq);
    endtask

    initial begin
        int pulses;
        n_vec = 0;
        n_bad = 0;
        RST = 1'b1; start = 1'b0; signed_op = 1'b0; A = '0; B = '0;
        #2;
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.q", quotient, 32'd0);
        chk("reset.r", remainder, 32'd0);
        chk("reset.dz", 32'(div_zero), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        run_op("u100_7",   32'd100,        32'd7,          1'b0, 0, 34, 32'd14,        32'd2,         1'b0);
        run_op("s-7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 0, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("s7_-2",    32'd7,          32'hFFFF_FFFE,  1'b1, 0, 34, 32'hFFFF_FFFD, 32'd1,         1'b0);
        run_op("s_min_-1", 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 0, 34, 32'h8000_0000, 32'd0,         1'b0);
        run_op("u_min_max",32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 0, 34, 32'd0,         32'h8000_0000, 1'b0);
        run_op("s5_0",     32'd5,          32'd0,          1'b1, 0, 1,  32'hFFFF_FFFF, 32'd5,         1'b1);
        run_op("u5_0",     32'd5,          32'd0,          1'b0, 0, 1,  32'hFFFF_FFFF, 32'd5,         1'b1);
        run_op("u9_3",     32'd9,          32'd3,          1'b0, 0, 34, 32'd3,         32'd0,         1'b0);
        run_op("u1000_10", 32'd1000,       32'd10,         1'b0, 5, 34, 32'd100,       32'd0,         1'b0);

        // Asynchronous reset in the middle of CALC
        @(posedge CLK); #1;
        A = 32'hFFFF_FFFF; B = 32'd3; signed_op = 1'b0; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        chk("rst_mid.busy", 32'(busy), 32'd0);
        chk("rst_mid.done", 32'(done), 32'd0);
        chk("rst_mid.q", quotient, 32'd0);
        chk("rst_mid.r", remainder, 32'd0);
        chk("rst_mid.dz", 32'(div_zero), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            pulses += int'(done);
            @(posedge CLK); #1;
        end
        chk("rst_mid.no_done", 32'(pulses), 32'd0);

        run_op("u_max_3",  32'hFFFF_FFFF,  32'd3,          1'b0, 0, 34, 32'h5555_5555, 32'd0,         1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
